// File: rtl/iir_pkg.sv
// Shared constants, sample type and quantiser for the IIR output path.
package iir_pkg;

  localparam int IN_W     = 22;
  localparam int IN_FRAC  = 14;
  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 12;
  localparam int RND_W    = IN_W - (IN_FRAC - OUT_FRAC) + 1;

  localparam logic signed [OUT_W-1:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_NEG = 16'sh8000;

  localparam logic signed [RND_W-1:0] RND_MAX = 21'sd32767;
  localparam logic signed [RND_W-1:0] RND_MIN = -21'sd32768;

  // Quantised sample travelling through the output buffer.
  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } q_sample_t;

  // Round to nearest (ties up) from En14 to En12, then clamp to 16 bits.
  // The rounding add is done one bit wider than the input so it cannot wrap.
  function automatic q_sample_t quantise(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0]    sum_s;
    logic signed [RND_W-1:0] rnd_s;
    q_sample_t               q_s;
    sum_s = {x[IN_W-1], x} + 23'sd2;
    rnd_s = sum_s[IN_W:2];
    if (rnd_s > RND_MAX) begin
      q_s.data = SAT_POS;
      q_s.sat  = 1'b1;
    end else if (rnd_s < RND_MIN) begin
      q_s.data = SAT_NEG;
      q_s.sat  = 1'b1;
    end else begin
      q_s.data = rnd_s[OUT_W-1:0];
      q_s.sat  = 1'b0;
    end
    return q_s;
  endfunction

endpackage

// File: rtl/iir_out_fifo2.sv
// Generic two-entry valid/ready FIFO with a global clock enable.
// Ready and valid depend only on the occupancy register.
module iir_out_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem0_r;
  logic [W-1:0] mem1_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic         push_fire_s;
  logic         pop_fire_s;

  assign push_ready  = (cnt_r != 2'd2);
  assign pop_valid   = (cnt_r != 2'd0);
  assign pop_data    = rd_ptr_r ? mem1_r : mem0_r;
  assign push_fire_s = push_valid & push_ready & en;
  assign pop_fire_s  = pop_valid & pop_ready & en;

  // Storage, single-bit wrapping pointers and occupancy update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem0_r   <= {W{1'b0}};
      mem1_r   <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else if (en) begin
      if (push_fire_s) begin
        if (wr_ptr_r) begin
          mem1_r <= push_data;
        end else begin
          mem0_r <= push_data;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_fire_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_fire_s, pop_fire_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/iir_out_stage.sv
// IIR output stage: quantise the final adder sum to sfix16_En12, buffer it
// in a two-entry FIFO and count samples that had to be saturated.
module iir_out_stage
  import iir_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_enable,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 sat_flag,
  input  logic                 sat_clear,
  output logic [SAT_CNT_W-1:0] sat_count
);

  q_sample_t              q_s;
  q_sample_t              head_s;
  logic                   in_fire_s;
  logic [SAT_CNT_W-1:0]   sat_cnt_r;

  assign q_s       = quantise(in_data);
  assign in_fire_s = in_valid & in_ready & clk_enable;
  assign out_data  = head_s.data;
  assign sat_flag  = head_s.sat;
  assign sat_count = sat_cnt_r;

  iir_out_fifo2 #(
    .W ($bits(q_sample_t))
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (clk_enable),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (q_s),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_s)
  );

  // Saturation event counter: clear wins over increment, sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_r <= {SAT_CNT_W{1'b0}};
    end else if (clk_enable) begin
      if (sat_clear) begin
        sat_cnt_r <= {SAT_CNT_W{1'b0}};
      end else if (in_fire_s && q_s.sat && (sat_cnt_r != {SAT_CNT_W{1'b1}})) begin
        sat_cnt_r <= sat_cnt_r + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_iir_out_stage.sv
// Self-checking bench for iir_out_stage: fixed vector table, scoreboard
// monitor, backpressure, sat_clear priority and mid-transfer reset sequences.
module tb_iir_out_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_enable;
  logic        in_valid;
  logic [21:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        sat_flag;
  logic        sat_clear;
  logic [15:0] sat_count;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct packed {
    logic        sat;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [21:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;

  exp_t        sbq[$];
  logic [15:0] exp_cnt = 16'd0;
  vec_t        tbl[12];

  iir_out_stage #(.SAT_CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag),
    .sat_clear  (sat_clear),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  // Reference quantiser using integer floor division.
  function automatic exp_t model(input logic [21:0] x);
    int   v;
    int   q;
    exp_t e;
    v = int'($signed(x)) + 2;
    if (v >= 0) q = v / 4;
    else        q = -((-v + 3) / 4);
    if (q > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (q < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = q[15:0];  e.sat = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, predicts the next rising edge.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!reset_n) begin
      sbq.delete();
      exp_cnt = 16'd0;
    end else begin
      check("sat_count", {16'd0, sat_count}, {16'd0, exp_cnt});
      check("out_valid_vs_occupancy", {31'd0, out_valid}, {31'd0, (sbq.size() > 0)});
      check("in_ready_vs_occupancy", {31'd0, in_ready}, {31'd0, (sbq.size() < 2)});
      if (clk_enable && out_valid && out_ready) begin
        got = '{sat: sat_flag, data: out_data};
        if (sbq.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL sb_unexpected_output: got %0h expected none", got);
        end else begin
          want = sbq.pop_front();
          check("sb_out", {15'd0, got}, {15'd0, want});
        end
      end
      if (clk_enable) begin
        if (sat_clear) begin
          exp_cnt = 16'd0;
        end else if (in_valid && in_ready && model(in_data).sat && exp_cnt != 16'hFFFF) begin
          exp_cnt = exp_cnt + 16'd1;
        end
        if (in_valid && in_ready) sbq.push_back(model(in_data));
      end
    end
  end

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send(input logic [21:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready && clk_enable) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      nchecks++;
      nerrors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nsat;
    bit ok;
    tbl[0]  = '{22'sd16384,    16'sd4096,  1'b0};
    tbl[1]  = '{22'sd6,        16'sd2,     1'b0};
    tbl[2]  = '{-22'sd6,       -16'sd1,    1'b0};
    tbl[3]  = '{22'sd5,        16'sd1,     1'b0};
    tbl[4]  = '{22'sd2,        16'sd1,     1'b0};
    tbl[5]  = '{-22'sd2,       16'sd0,     1'b0};
    tbl[6]  = '{22'sh1FFFFF,   16'h7FFF,   1'b1};
    tbl[7]  = '{22'sh200000,   16'h8000,   1'b1};
    tbl[8]  = '{22'sd131068,   16'h7FFF,   1'b0};
    tbl[9]  = '{22'sd131070,   16'h7FFF,   1'b1};
    tbl[10] = '{-22'sd131074,  16'h8000,   1'b0};
    tbl[11] = '{-22'sd131075,  16'h8000,   1'b1};

    reset_n = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; in_data = 22'd0;
    out_ready = 1'b0; sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    check("rst_sat_count", {16'd0, sat_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    // Table: one sample at a time, FIFO empty, one-cycle latency.
    out_ready = 1'b1;
    nsat = 0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].din);
      @(negedge clk);
      check($sformatf("tbl%0d_latency_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("tbl%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].dout});
      check($sformatf("tbl%0d_sat", i), {31'd0, sat_flag}, {31'd0, tbl[i].sat});
      if (tbl[i].sat) nsat++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tbl_sat_count", {16'd0, sat_count}, nsat);

    // Backpressure: two accepted, third held until space frees up.
    @(posedge clk); #1 out_ready = 1'b0;
    send(22'sd16384);
    send(22'sd8192);
    @(negedge clk);
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = -22'sd16384;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
      check("bp_head_stable", {16'd0, out_data}, 32'h1000);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low_on_pop_cycle", {31'd0, in_ready}, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("bp_third_accepted", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);

    // sat_clear on the same edge as a saturated accept.
    send(22'sh1FFFFF);
    @(negedge clk);
    check("sc_count_before", {16'd0, sat_count}, {16'd0, exp_cnt});
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 22'sh200000; sat_clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sat_clear = 1'b0;
    @(negedge clk);
    check("sc_clear_wins", {16'd0, sat_count}, 32'd0);
    repeat (4) @(posedge clk);

    // Random traffic with enable gaps and occasional clears.
    for (int c = 0; c < 600; c++) begin
      int mode;
      logic [31:0] r;
      @(posedge clk); #1;
      mode = $urandom_range(0, 3);
      r = $urandom;
      case (mode)
        0:       in_data = r[21:0];
        1:       in_data = 22'(131060 + $urandom_range(0, 20));
        2:       in_data = 22'(-131085 + $urandom_range(0, 25));
        default: in_data = 22'($urandom_range(0, 40) - 20);
      endcase
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clk_enable = ($urandom_range(0, 9) != 0);
      sat_clear  = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; sat_clear = 1'b0; clk_enable = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge clk);

    // Reset while full: everything clears at once, nothing stale afterwards.
    @(posedge clk); #1 out_ready = 1'b0;
    send(22'sh1FFFFF);
    send(22'sd4000);
    @(negedge clk);
    check("rst_mid_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_sat_count", {16'd0, sat_count}, 32'd0);
    check("rst_mid_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/iir_out_stage.md
IIR_OUT_STAGE -- requirements
Module: iir_out_stage

Interface
REQ-001 Parameter SAT_CNT_W, default 16, width of saturation event counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 clk_enable  in  1  global enable; when low, all state holds and no handshake completes.
REQ-005 in_valid  in  1  filter sum output valid.
REQ-006 in_data  in  22  signed sfix22_En14, final feedforward adder output.
REQ-007 in_ready  out  1  stage can accept a sample.
REQ-008 out_valid  out  1  quantised sample available.
REQ-009 out_data  out  16  signed sfix16_En12 quantised sample.
REQ-010 out_ready  in  1  downstream accepts out_data.
REQ-011 sat_flag  out  1  head-of-buffer sample was saturated.
REQ-012 sat_clear  in  1  synchronous clear of sat_count.
REQ-013 sat_count  out  SAT_CNT_W  number of saturated samples accepted.

Function
REQ-014 Input handshake completes when in_valid & in_ready & clk_enable are all high on a rising edge.
REQ-015 Output handshake completes when out_valid & out_ready & clk_enable are all high on a rising edge.
REQ-016 Quantisation: round to nearest, ties up: add 1 at in_data bit 1, then arithmetic shift right 2 (En14 -> En12), computed in 21 bits without wrap.
REQ-017 Saturation: rounded value > 32767 gives 16'sh7FFF, < -32768 gives 16'sh8000; sat bit set for either case.
REQ-018 Quantised value and its sat bit are stored together in a 2-entry FIFO, depth 2, occupancy count 0..2.
REQ-019 in_ready = (count < 2); combinational from state only, never from in_valid or out_ready.
REQ-020 out_valid = (count > 0); out_data and sat_flag come from the FIFO head.
REQ-021 Latency: a sample accepted at edge N appears on out_data after edge N when the FIFO was empty, i.e. one cycle.
REQ-022 Simultaneous push and pop at count 1: count stays 1, the popped entry leaves and the new entry becomes head on the next cycle.
REQ-023 Simultaneous push and pop at count 0 cannot occur, because out_valid is low.
REQ-024 At count 2, in_ready is low, so a pop alone moves count to 1 and in_ready rises the following cycle.
REQ-025 out_data and sat_flag stay stable while out_valid is high and out_ready is low.
REQ-026 sat_count increments by 1 on each accepted input whose sat bit is set, and saturates at all-ones without wrapping.
REQ-027 sat_clear has priority over increment: when both occur on the same edge, sat_count becomes 0.
REQ-028 FIFO pointers wrap modulo 2.

Reset
REQ-029 Reset asserted (reset_n low) immediately sets count 0, pointers 0, sat_count 0, out_valid 0, out_data 0, sat_flag 0, and in_ready 1 once state has cleared.
REQ-030 Reset mid-transfer discards all buffered samples; no partial output follows release.
REQ-031 Reset release is synchronised by the existing top-level reset bridge; the block itself needs no synchroniser.

Structure
REQ-032 Shared package iir_pkg holds IN_W=22, IN_FRAC=14, OUT_W=16, OUT_FRAC=12, the saturation constants, and the quantiser function.
REQ-033 One sub-module, iir_out_fifo2, a generic 2-entry valid/ready FIFO; rounding and saturation stay in the parent.

Verification
REQ-034 in_data 22'sd16384 (1.0), out_ready=1 -> out_data 16'sd4096, sat_flag=0, out_valid high one cycle after acceptance.
REQ-035 Rounding: in_data 22'sd6 -> 16'sd2; in_data -22'sd6 -> -16'sd1; in_data 22'sd5 -> 16'sd1.
REQ-036 Saturation: in_data 22'sh1FFFFF -> 16'sh7FFF with sat_flag=1; in_data 22'sh200000 -> 16'sh8000 with sat_flag=1; sat_count=2.
REQ-037 Backpressure: out_ready=0 and 3 samples offered -> 2 accepted, in_ready low at count 2, third sample held upstream; after out_ready=1, order is preserved and the third sample is accepted.
REQ-038 Reset asserted with count=2 -> out_valid 0, in_ready 1, sat_count 0 immediately, no stale samples after release.
REQ-039 sat_clear on the same edge as a saturated accept -> sat_count=0.
